// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between fetch and data requesters; responses return in order by owner.
// Optional fetch starvation guard is built when the macro ARB_STARVE_GUARD_EN is defined.
module sram_port_arbiter #(
  parameter int SRAM_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  if (SRAM_LAT < 1 || SRAM_LAT > 4 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("sram_port_arbiter: SRAM_LAT must be 1..4 and STARVE_MAX at least 1");
  end

  logic grant_inst;
  logic grant_data;
  logic force_inst;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Fetch wins a contested cycle once it has been denied STARVE_MAX cycles in a row.
  assign force_inst = inst_req && data_req && (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || grant_inst) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign force_inst = 1'b0;
`endif

  assign grant_data   = data_req && !force_inst;
  assign grant_inst   = inst_req && !grant_data;
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  always_comb begin
    sram_en    = grant_inst || grant_data;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_data) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (grant_inst) begin
      sram_addr  = inst_addr;
    end
  end

  // ---- owner pipeline: stage 0 captures each grant, last stage raises data_ok ----
  logic vld_p [SRAM_LAT];
  logic own_p [SRAM_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SRAM_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= sram_en;
      for (int i = 1; i < SRAM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Owner bits are qualified by vld_p, so they need no reset.
  always_ff @(posedge clk) begin
    own_p[0] <= grant_data;
    for (int i = 1; i < SRAM_LAT; i++) own_p[i] <= own_p[i-1];
  end

  // ---- response stage ----
  assign inst_data_ok = vld_p[SRAM_LAT-1] && !own_p[SRAM_LAT-1];
  assign data_data_ok = vld_p[SRAM_LAT-1] &&  own_p[SRAM_LAT-1];
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances (SRAM_LAT 1,2,3) share stimulus and are checked every cycle
// against a cycle-indexed response schedule and a word-level memory model.
module tb_sram_port_arbiter;
  localparam int NI         = 3;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic [3:0]  data_we = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;

  logic        ia_ok [NI];
  logic        id_ok [NI];
  logic        da_ok [NI];
  logic        dd_ok [NI];
  logic        s_en  [NI];
  logic [3:0]  s_we  [NI];
  logic [31:0] i_rd  [NI];
  logic [31:0] d_rd  [NI];
  logic [31:0] s_addr[NI];
  logic [31:0] s_wd  [NI];
  logic [31:0] s_rd  [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h02800c0c : (32'h1357_9bdf ^ (32'(i) * 32'h0101_0101));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [31:0] mem  [16];
    logic [31:0] pipe [LAT];

    sram_port_arbiter #(.SRAM_LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(ia_ok[g]),
      .inst_data_ok(id_ok[g]), .inst_rdata(i_rd[g]),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(da_ok[g]), .data_data_ok(dd_ok[g]), .data_rdata(d_rd[g]),
      .sram_en(s_en[g]), .sram_we(s_we[g]), .sram_addr(s_addr[g]), .sram_wdata(s_wd[g]),
      .sram_rdata(s_rd[g])
    );

    // SRAM macro model: word-indexed by addr[5:2], read data appears LAT cycles after enable.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else begin
        pipe[0] <= (s_en[g] && s_we[g] == 4'h0) ? mem[s_addr[g][5:2]] : 32'h0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        if (s_en[g] && s_we[g] != 4'h0) mem[s_addr[g][5:2]] <= merge(mem[s_addr[g][5:2]], s_wd[g], s_we[g]);
      end
    end
    assign s_rd[g] = pipe[LAT-1];
  end

  // Reference model: grants from the priority rules, responses scheduled in a cycle-indexed ring.
  int          cyc = 0;
  int          run = 0;
  logic        exp_gi = 1'b0;
  logic        exp_gd = 1'b0;
  logic        sv [NI][8];
  logic        so [NI][8];
  logic        sr [NI][8];
  logic [31:0] sd [NI][8];
  logic [31:0] ref_mem [16];

  always @(negedge clk) begin
    logic        force_i;
    logic [31:0] ea, e_addr, e_wd;
    logic [3:0]  e_we;
    int          s, t;
    if (reset) begin
      exp_gi = 1'b0;
      exp_gd = 1'b0;
      run    = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      for (int g = 0; g < NI; g++) begin
        for (int k = 0; k < 8; k++) sv[g][k] = 1'b0;
        chk($sformatf("lat%0d rst_outs", g + 1),
            {20'h0, ia_ok[g], id_ok[g], da_ok[g], dd_ok[g], s_en[g], 3'h0, s_we[g]}, 32'h0);
        chk($sformatf("lat%0d rst_buses", g + 1), s_addr[g] | s_wd[g] | i_rd[g] | d_rd[g], 32'h0);
      end
    end else begin
      force_i = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      force_i = inst_req && data_req && (run >= STARVE_MAX);
`endif
      exp_gd = data_req && !force_i;
      exp_gi = inst_req && !exp_gd;
      e_we   = exp_gd ? data_we : 4'h0;
      e_addr = exp_gd ? data_addr : (exp_gi ? inst_addr : 32'h0);
      e_wd   = exp_gd ? data_wdata : 32'h0;
      ea     = exp_gd ? data_addr : inst_addr;
      s      = cyc % 8;
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("lat%0d inst_addr_ok", g + 1), 32'(ia_ok[g]), 32'(exp_gi));
        chk($sformatf("lat%0d data_addr_ok", g + 1), 32'(da_ok[g]), 32'(exp_gd));
        chk($sformatf("lat%0d sram_en", g + 1), 32'(s_en[g]), 32'(exp_gi || exp_gd));
        chk($sformatf("lat%0d sram_we", g + 1), 32'(s_we[g]), 32'(e_we));
        chk($sformatf("lat%0d sram_addr", g + 1), s_addr[g], e_addr);
        chk($sformatf("lat%0d sram_wdata", g + 1), s_wd[g], e_wd);
        chk($sformatf("lat%0d inst_data_ok", g + 1), 32'(id_ok[g]), 32'(sv[g][s] && !so[g][s]));
        chk($sformatf("lat%0d data_data_ok", g + 1), 32'(dd_ok[g]), 32'(sv[g][s] && so[g][s]));
        if (sv[g][s] && sr[g][s])
          chk($sformatf("lat%0d rdata", g + 1), so[g][s] ? d_rd[g] : i_rd[g], sd[g][s]);
        sv[g][s] = 1'b0;
        if (exp_gi || exp_gd) begin
          t = (cyc + g + 1) % 8;
          sv[g][t] = 1'b1;
          so[g][t] = exp_gd;
          sr[g][t] = exp_gi || (data_we == 4'h0);
          sd[g][t] = ref_mem[ea[5:2]];
        end
      end
      if (exp_gd && data_we != 4'h0) ref_mem[ea[5:2]] = merge(ref_mem[ea[5:2]], data_wdata, data_we);
      run = (inst_req && !exp_gi) ? run + 1 : 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   first_i, cnt;
    logic d4, d5;
    int   code [7];

    repeat (2) tick();
    @(negedge clk);
    chk("reset sram_en", 32'(s_en[0]), 32'h0);
    chk("reset data_data_ok", 32'(dd_ok[1]), 32'h0);
    tick();
    reset = 1'b0;

    // Single fetch with known memory contents.
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    @(negedge clk);
    chk("fetch addr_ok", 32'(ia_ok[0]), 32'h1);
    chk("fetch no data_ok N", 32'(dd_ok[0]), 32'h0);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("fetch data_ok", 32'(id_ok[0]), 32'h1);
    chk("fetch rdata", i_rd[0], 32'h02800c0c);
    chk("fetch no data_ok N+1", 32'(dd_ok[0]), 32'h0);
    tick();

    // Contested cycle: data write wins, fetch follows.
    inst_req = 1'b1; inst_addr = 32'h1c000004;
    data_req = 1'b1; data_we = 4'hF; data_addr = 32'h100; data_wdata = 32'hdeadbeef;
    @(negedge clk);
    chk("contest sram_we", 32'(s_we[0]), 32'hF);
    chk("contest sram_addr", s_addr[0], 32'h100);
    chk("contest data_addr_ok", 32'(da_ok[0]), 32'h1);
    chk("contest inst_addr_ok", 32'(ia_ok[0]), 32'h0);
    tick();
    data_req = 1'b0; data_we = 4'h0;
    @(negedge clk);
    chk("contest next inst_addr_ok", 32'(ia_ok[0]), 32'h1);
    chk("contest next data_data_ok", 32'(dd_ok[0]), 32'h1);
    tick();
    inst_req = 1'b0;
    repeat (3) tick();

    // Starvation: both requesters held high for 50 cycles.
    first_i = -1; d4 = 1'b0; d5 = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1c000010;
    data_req = 1'b1; data_we = 4'h0; data_addr = 32'h200;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ia_ok[0] && first_i < 0) first_i = k;
      if (k == 4) d4 = da_ok[0];
      if (k == 5) d5 = da_ok[0];
      tick();
      if (exp_gi) inst_addr = inst_addr + 32'h4;
      if (exp_gd) data_addr = data_addr + 32'h4;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve first inst grant", 32'(first_i), 32'd4);
    chk("starve data denied c4", 32'(d4), 32'h0);
    chk("starve data granted c5", 32'(d5), 32'h1);
`else
    chk("starve inst never granted", 32'(first_i), 32'hffffffff);
    chk("starve data c4", 32'(d4), 32'h1);
    chk("starve data c5", 32'(d5), 32'h1);
`endif
    inst_req = 1'b0; data_req = 1'b0;
    repeat (4) tick();

    // Back-to-back inst, data, inst; observe the SRAM_LAT=3 instance.
    inst_req = 1'b1; inst_addr = 32'h1c000020;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      code[k] = id_ok[2] ? 1 : (dd_ok[2] ? 2 : 0);
      tick();
      case (k)
        0: begin inst_req = 1'b0; data_req = 1'b1; data_we = 4'h0; data_addr = 32'h108; end
        1: begin data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00002c; end
        2: inst_req = 1'b0;
        default: ;
      endcase
    end
    chk("b2b order c3", 32'(code[3]), 32'd1);
    chk("b2b order c4", 32'(code[4]), 32'd2);
    chk("b2b order c5", 32'(code[5]), 32'd1);
    chk("b2b quiet c6", 32'(code[6]), 32'd0);

    // Reset one cycle after a data read is accepted.
    data_req = 1'b1; data_we = 4'h0; data_addr = 32'h104;
    tick();
    data_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst lat2 data_data_ok", 32'(dd_ok[1]), 32'h0);
    chk("midrst lat2 rdata", d_rd[1], 32'h0);
    tick();
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dd_ok[1]) cnt++;
      tick();
    end
    chk("midrst no late data_ok", 32'(cnt), 32'h0);

    // Randomised traffic with withdrawals and occasional reset pulses.
    for (int k = 0; k < 3000; k++) begin
      if (exp_gi) inst_req = 1'b0;
      if (exp_gd) data_req = 1'b0;
      if (inst_req && $urandom_range(0, 9) == 0) inst_req = 1'b0;
      if (data_req && $urandom_range(0, 9) == 0) data_req = 1'b0;
      if (!inst_req && $urandom_range(0, 1) == 1) begin
        inst_req  = 1'b1;
        inst_addr = $urandom;
      end
      if (!data_req && $urandom_range(0, 4) != 0) begin
        data_req   = 1'b1;
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_we    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        inst_req = 1'b0; data_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
